// File: rtl/branch_unit.sv
// Branch/jump resolution unit: an 8x8 register file feeds a combinational
// target selector whose result is registered into PC and taken.
module branch_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data,
    input  logic [7:0]  NPC,
    input  logic        we,
    input  logic [2:0]  wa,
    input  logic [7:0]  wd,
    output logic [7:0]  PC,
    output logic        taken
);

    localparam logic [4:0] OP_BEQZ  = 5'b10011;
    localparam logic [4:0] OP_BNEZ  = 5'b10100;
    localparam logic [4:0] OP_BEQZR = 5'b10101;
    localparam logic [4:0] OP_BNEZR = 5'b10110;
    localparam logic [4:0] OP_JMP   = 5'b10111;
    localparam logic [4:0] OP_JR    = 5'b11000;

    logic [7:0] regs_r [8];
    logic [7:0] pc_r;
    logic       taken_r;

    logic [4:0] opcode_s;
    logic [7:0] r1_val_s;
    logic [7:0] r2_val_s;
    logic [7:0] m_s;
    logic       r1_zero_s;
    logic [7:0] target_s;
    logic       take_s;

    // Full 8-bit zero test, unsigned.
    function automatic logic is_zero(input logic [7:0] v);
        return (v == 8'h00);
    endfunction

    // Register file: cleared asynchronously, written on the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else if (we) begin
            regs_r[wa] <= wd;
        end
    end

    // Target selection from pre-edge register contents.
    always_comb begin
        opcode_s  = data[15:11];
        r1_val_s  = regs_r[data[10:8]];
        r2_val_s  = regs_r[data[2:0]];
        m_s       = data[7:0];
        r1_zero_s = is_zero(r1_val_s);
        target_s  = NPC;
        take_s    = 1'b0;
        case (opcode_s)
            OP_BEQZ: begin
                if (r1_zero_s) begin
                    target_s = m_s;
                    take_s   = 1'b1;
                end else begin
                    target_s = NPC;
                    take_s   = 1'b0;
                end
            end
            OP_BNEZ: begin
                if (!r1_zero_s) begin
                    target_s = m_s;
                    take_s   = 1'b1;
                end else begin
                    target_s = NPC;
                    take_s   = 1'b0;
                end
            end
            OP_BEQZR: begin
                if (r1_zero_s) begin
                    target_s = r2_val_s;
                    take_s   = 1'b1;
                end else begin
                    target_s = NPC;
                    take_s   = 1'b0;
                end
            end
            OP_BNEZR: begin
                if (!r1_zero_s) begin
                    target_s = r2_val_s;
                    take_s   = 1'b1;
                end else begin
                    target_s = NPC;
                    take_s   = 1'b0;
                end
            end
            OP_JMP: begin
                target_s = m_s;
                take_s   = 1'b1;
            end
            OP_JR: begin
                target_s = r2_val_s;
                take_s   = 1'b1;
            end
            default: begin
                target_s = NPC;
                take_s   = 1'b0;
            end
        endcase
    end

    // PC and taken register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r    <= 8'h00;
            taken_r <= 1'b0;
        end else begin
            pc_r    <= target_s;
            taken_r <= take_s;
        end
    end

    assign PC    = pc_r;
    assign taken = taken_r;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed vector table, hand-written
// reset sequences, and randomized traffic against a behavioural model.
module tb_branch_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] data;
    logic [7:0]  NPC;
    logic        we;
    logic [2:0]  wa;
    logic [7:0]  wd;
    logic [7:0]  PC;
    logic        taken;

    int checks;
    int passes;

    logic [7:0] model_regs [8];

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [7:0]  wd;
        logic [15:0] data;
        logic [7:0]  npc;
        logic [7:0]  exp_pc;
        logic        exp_taken;
    } vec_t;

    vec_t vecs [18];

    branch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .NPC   (NPC),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .PC    (PC),
        .taken (taken)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: branch semantics straight from the opcode table.
    function automatic void model_next(input logic [15:0] d, input logic [7:0] npc,
                                       output logic [7:0] t, output logic k);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] dest;
        logic       cond;
        a = model_regs[d[10:8]];
        b = model_regs[d[2:0]];
        cond = 1'b0;
        dest = npc;
        case (d[15:11])
            5'd19: begin cond = (a == 8'd0); dest = d[7:0]; end
            5'd20: begin cond = (a != 8'd0); dest = d[7:0]; end
            5'd21: begin cond = (a == 8'd0); dest = b; end
            5'd22: begin cond = (a != 8'd0); dest = b; end
            5'd23: begin cond = 1'b1; dest = d[7:0]; end
            5'd24: begin cond = 1'b1; dest = b; end
            default: cond = 1'b0;
        endcase
        k = cond;
        t = cond ? dest : npc;
    endfunction

    task automatic drive(input logic w, input logic [2:0] a, input logic [7:0] v,
                         input logic [15:0] d, input logic [7:0] n);
        we = w; wa = a; wd = v; data = d; NPC = n;
    endtask

    task automatic edge_and_commit(input logic w, input logic [2:0] a, input logic [7:0] v);
        @(posedge clk);
        #1;
        if (w) model_regs[a] = v;
    endtask

    task automatic rand_step(input int idx);
        logic [15:0] d;
        logic [7:0]  n;
        logic [7:0]  exp_t;
        logic        exp_k;
        logic        w;
        logic [2:0]  a;
        logic [7:0]  v;
        d = 16'($urandom);
        if ($urandom_range(0, 3) != 0) d[15:11] = 5'($urandom_range(19, 24));
        // Bias register values toward zero so both branch outcomes occur.
        v = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
        w = 1'($urandom);
        a = 3'($urandom);
        n = 8'($urandom);
        model_next(d, n, exp_t, exp_k);
        drive(w, a, v, d, n);
        edge_and_commit(w, a, v);
        check($sformatf("rand%0d_pc", idx), PC, exp_t);
        check($sformatf("rand%0d_taken", idx), {7'd0, taken}, {7'd0, exp_k});
    endtask

    initial begin
        logic [7:0] t;
        logic       k;
        checks = 0;
        passes = 0;
        for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;

        vecs[0]  = '{1'b0, 3'd0, 8'h00, 16'h9ED5, 8'h09, 8'hD5, 1'b1};
        vecs[1]  = '{1'b1, 3'd6, 8'h05, 16'h0000, 8'h09, 8'h09, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, 8'h00, 16'h9ED5, 8'h09, 8'h09, 1'b0};
        vecs[3]  = '{1'b1, 3'd6, 8'h03, 16'h0000, 8'h10, 8'h10, 1'b0};
        vecs[4]  = '{1'b0, 3'd0, 8'h00, 16'hA6D5, 8'h09, 8'hD5, 1'b1};
        vecs[5]  = '{1'b1, 3'd6, 8'h00, 16'h0000, 8'h20, 8'h20, 1'b0};
        vecs[6]  = '{1'b0, 3'd0, 8'h00, 16'hA6D5, 8'h09, 8'h09, 1'b0};
        vecs[7]  = '{1'b1, 3'd5, 8'h40, 16'h0000, 8'h30, 8'h30, 1'b0};
        vecs[8]  = '{1'b0, 3'd0, 8'h00, 16'hAED5, 8'h09, 8'h40, 1'b1};
        vecs[9]  = '{1'b0, 3'd0, 8'h00, 16'hB6D5, 8'h09, 8'h09, 1'b0};
        vecs[10] = '{1'b0, 3'd0, 8'h00, 16'hBCD5, 8'h09, 8'hD5, 1'b1};
        vecs[11] = '{1'b1, 3'd5, 8'h77, 16'h0000, 8'hFF, 8'hFF, 1'b0};
        vecs[12] = '{1'b0, 3'd0, 8'h00, 16'hC0D5, 8'h09, 8'h77, 1'b1};
        vecs[13] = '{1'b0, 3'd0, 8'h00, 16'h0000, 8'h42, 8'h42, 1'b0};
        vecs[14] = '{1'b0, 3'd0, 8'h00, 16'hBBAB, 8'h09, 8'hAB, 1'b1};
        vecs[15] = '{1'b1, 3'd6, 8'h01, 16'h0000, 8'h01, 8'h01, 1'b0};
        vecs[16] = '{1'b1, 3'd6, 8'h00, 16'h9ED5, 8'h09, 8'h09, 1'b0};
        vecs[17] = '{1'b0, 3'd0, 8'h00, 16'h9ED5, 8'h09, 8'hD5, 1'b1};

        drive(1'b0, 3'd0, 8'h00, 16'h0000, 8'h00);
        rst_n = 1'b0;
        #12;
        check("reset_pc", PC, 8'h00);
        check("reset_taken", {7'd0, taken}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].data, vecs[i].npc);
            edge_and_commit(vecs[i].we, vecs[i].wa, vecs[i].wd);
            check($sformatf("vec%0d_pc", i), PC, vecs[i].exp_pc);
            check($sformatf("vec%0d_taken", i), {7'd0, taken}, {7'd0, vecs[i].exp_taken});
        end

        for (int i = 0; i < 300; i++) rand_step(i);

        // Fill registers with nonzero values, then land PC on 0xD5.
        for (int r = 0; r < 8; r++) begin
            drive(1'b1, 3'(r), 8'(8'h11 + 8'(r)), 16'h0000, 8'h03);
            edge_and_commit(1'b1, 3'(r), 8'(8'h11 + 8'(r)));
        end
        drive(1'b0, 3'd0, 8'h00, 16'hBCD5, 8'h09);
        edge_and_commit(1'b0, 3'd0, 8'h00);
        check("prereset_pc", PC, 8'hD5);

        // Mid-cycle reset with a write pending.
        drive(1'b1, 3'd2, 8'hFF, 16'hBC33, 8'h44);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
        check("midreset_pc", PC, 8'h00);
        check("midreset_taken", {7'd0, taken}, 8'h00);
        @(posedge clk);
        #1;
        check("heldreset_pc", PC, 8'h00);
        check("heldreset_taken", {7'd0, taken}, 8'h00);
        drive(1'b0, 3'd0, 8'h00, 16'h0000, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Every register must read zero: BEQZ Rr must be taken.
        for (int r = 0; r < 8; r++) begin
            logic [15:0] d;
            d = {5'b10011, 3'(r), 8'(8'h80 + 8'(r))};
            model_next(d, 8'h05, t, k);
            drive(1'b0, 3'd0, 8'h00, d, 8'h05);
            edge_and_commit(1'b0, 3'd0, 8'h00);
            check($sformatf("zero_r%0d_pc", r), PC, 8'(8'h80 + 8'(r)));
            check($sformatf("zero_r%0d_taken", r), {7'd0, taken}, {7'd0, k});
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (instruction 16 bits, addresses 8 bits, 8 registers of 8 bits).
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 data  input  16  current instruction: [15:11] opcode, [10:8] R1, [7:0] address M, [2:0] R2.
REQ-006 NPC  input  8  sequential next address (current PC + 1, supplied externally).
REQ-007 we  input  1  register-file write enable.
REQ-008 wa  input  3  register-file write index.
REQ-009 wd  input  8  register-file write data.
REQ-010 PC  output  8  registered program counter.
REQ-011 taken  output  1  registered flag; 1 when the last update of PC was a branch or jump target rather than NPC.

Function
REQ-012 The block SHALL contain an 8-entry x 8-bit register file, reg[0..7], all entries general purpose, with no hard-wired zero.
REQ-013 The register file SHALL be written on the rising clk edge when we=1: reg[wa] <= wd.
REQ-014 Register reads for branch decode SHALL be combinational from the current (pre-edge) contents; a same-edge write to the read register SHALL NOT affect that edge's decision.
REQ-015 The block SHALL compute the combinational target T and flag K from the opcode as follows:
- 10011 BEQZ: T = M if reg[R1] == 0, else NPC.
- 10100 BNEZ: T = M if reg[R1] != 0, else NPC.
- 10101 BEQZR: T = reg[R2] if reg[R1] == 0, else NPC.
- 10110 BNEZR: T = reg[R2] if reg[R1] != 0, else NPC.
- 10111 JMP: T = M, unconditional.
- 11000 JR: T = reg[R2], unconditional (register field [2:0]).
- Any other opcode: T = NPC, K = 0.
REQ-016 K SHALL be 1 exactly when T was selected from M or a register value rather than NPC.
REQ-017 On each rising clk edge with rst_n=1: PC <= T and taken <= K; latency is one cycle from data/NPC to PC.
REQ-018 The zero test SHALL cover all 8 bits of the register value; no sign interpretation is applied.
REQ-019 Don't-care bits ([10:8] for JMP/JR, [7:3] for register forms) SHALL NOT influence the result.
REQ-020 No arithmetic SHALL be performed on NPC or the targets; all values pass through unmodified with 8-bit width, so NPC = 0xFF is taken as-is with no wrap logic.
REQ-021 Unknown or undefined opcodes, including 16'h0000, SHALL behave as non-branch: PC <= NPC.

Reset
REQ-022 While rst_n=0, the block SHALL force PC = 8'h00, taken = 0, and all reg[0..7] = 8'h00, immediately and independent of clk.
REQ-023 After rst_n is released, the first rising edge SHALL perform a normal update.
REQ-024 A reset asserted mid-operation SHALL discard any pending write and update, and its effect SHALL be visible before the next edge.

Verification
REQ-025 Reset, then NPC=9, data=16'h9ED5 (BEQZ R6, M=0xD5) with reg6=0 -> after one edge PC=0xD5, taken=1; with reg6=5 -> PC=0x09, taken=0.
REQ-026 data=16'hA6D5 (BNEZ R6) with reg6=3 -> PC=0xD5; with reg6=0 -> PC=0x09.
REQ-027 reg5=0x40, data=16'hAED5 (BEQZR R6, R2=5) with reg6=0 -> PC=0x40; data=16'hB6D5 (BNEZR) with reg6=0 -> PC=0x09.
REQ-028 data=16'hBCD5 (JMP) -> PC=0xD5; reg5=0x77, data=16'hC0D5 (JR R5) -> PC=0x77; data=16'h0000 -> PC=NPC, taken=0.
REQ-029 Same-edge write of reg6=0 while reg6=1 and BEQZ R6 is presented -> PC=NPC; the following edge -> PC=0xD5.
REQ-030 Assert rst_n=0 between clock edges after PC=0xD5 -> PC=0x00 and taken=0 immediately, and every register reads 0.
